// File: rtl/meas_pkg.sv
// meas_pkg: AFE phase encodings, sequencer states and the
// result-word layout {ch, ovr, sign, count}.
package meas_pkg;

  localparam logic [1:0] AFE_IDLE  = 2'b00;
  localparam logic [1:0] AFE_AZ    = 2'b01;
  localparam logic [1:0] AFE_INT   = 2'b10;
  localparam logic [1:0] AFE_DEINT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_AZ,
    S_INT,
    S_DEINT,
    S_ACCUM,
    S_NEXT
  } state_t;

  function automatic int res_sign_lsb(int cnt_w);
    return cnt_w;
  endfunction

  function automatic int res_ovr_lsb(int cnt_w);
    return cnt_w + 1;
  endfunction

  function automatic int res_ch_lsb(int cnt_w);
    return cnt_w + 2;
  endfunction

  function automatic int res_width(int ch_w, int cnt_w);
    return ch_w + cnt_w + 2;
  endfunction

endpackage

// File: rtl/meas_result_fifo.sv
// meas_result_fifo: first-word-fall-through result buffer.
// Ports: push_i/data_i write, pop_i read, data_o head, empty_o/full_o.
module meas_result_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr == rd_ptr);
  assign full_o  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0])
                && (wr_ptr[AW] != rd_ptr[AW]);

  // A pop frees the head slot this cycle, so a push into a
  // full buffer is accepted when it coincides with a pop.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign data_o = empty_o ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/meas_sequencer.sv
// meas_sequencer: multi-channel dual-slope conversion sequencer.
// Ports: start/abort/mask control, comp/ready from AFE, AFE phase
// and mux outputs, FWFT result port, sticky overflow, scan irq.
module meas_sequencer
  import meas_pkg::*;
#(
  parameter  int NUM_CH     = 4,
  parameter  int CNT_W      = 12,
  parameter  int INT_CYCLES = 1024,
  parameter  int AZ_CYCLES  = 64,
  parameter  int AVG_LOG2   = 2,
  parameter  int FIFO_DEPTH = 8,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int RES_W = res_width(CH_W, CNT_W)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              continuous_i,
  input  logic              abort_i,
  input  logic [NUM_CH-1:0] ch_mask_i,
  input  logic              comp_i,
  input  logic              analog_ready_i,
  output logic [1:0]        afe_sel_o,
  output logic [CH_W-1:0]   ch_sel_o,
  output logic              ref_sign_o,
  output logic              busy_o,
  output logic [RES_W-1:0]  res_data_o,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic              fifo_ovf_o,
  output logic              irq_o
);

  localparam int PH_MAX = (INT_CYCLES > AZ_CYCLES)
                        ? INT_CYCLES : AZ_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int ACC_W  = CNT_W + AVG_LOG2;
  localparam int CV_W   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int R_CH   = res_ch_lsb(CNT_W);
  localparam int R_OVR  = res_ovr_lsb(CNT_W);
  localparam int R_SGN  = res_sign_lsb(CNT_W);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [PH_W-1:0]  AZ_LAST  = PH_W'(AZ_CYCLES - 1);
  localparam logic [PH_W-1:0]  INT_LAST = PH_W'(INT_CYCLES - 1);
  localparam logic [CV_W-1:0]  CV_LAST  =
    CV_W'((1 << AVG_LOG2) - 1);

  state_t            state;
  state_t            nstate;
  logic [NUM_CH-1:0] mask;
  logic [CH_W-1:0]   ch;
  logic [PH_W-1:0]   ph;
  logic [CNT_W-1:0]  cnt;
  logic              sign;
  logic              ovr;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_sum;
  logic              ovr_acc;
  logic [CV_W-1:0]   conv;
  logic              ovf;
  logic              irq;
  logic              irq_n;
  logic              push;
  logic              full;
  logic              empty;
  logic              flip;
  logic              sat;
  logic              last_conv;
  logic [CH_W:0]     first;
  logic [CH_W:0]     restart;
  logic [CH_W:0]     nxt;
  logic [RES_W-1:0]  push_data;

  // {found, index} of the lowest set bit at or above 'from'.
  function automatic logic [CH_W:0] find_set(
    input logic [NUM_CH-1:0] m,
    input int                from
  );
    find_set = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i] && i >= from) find_set = {1'b1, CH_W'(i)};
    end
  endfunction

  always_comb begin
    first     = find_set(ch_mask_i, 0);
    restart   = find_set(mask, 0);
    nxt       = find_set(mask, int'(ch) + 1);
    acc_sum   = acc + ACC_W'(cnt);
    last_conv = (conv == CV_LAST);
    flip      = (comp_i != sign);
    sat       = (cnt == CNT_MAX);
  end

  always_comb begin
    push_data = '0;
    push_data[R_CH +: CH_W]    = ch;
    push_data[R_OVR]           = ovr_acc | ovr;
    push_data[R_SGN]           = sign;
    push_data[0 +: CNT_W]      = acc_sum[AVG_LOG2 +: CNT_W];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate    = state;
    afe_sel_o = AFE_IDLE;
    push      = 1'b0;
    irq_n     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start_i && first[CH_W]) nstate = S_SETTLE;
      end
      S_SETTLE: begin
        afe_sel_o = AFE_AZ;
        if (analog_ready_i) nstate = S_AZ;
      end
      S_AZ: begin
        afe_sel_o = AFE_AZ;
        if (ph == AZ_LAST) nstate = S_INT;
      end
      S_INT: begin
        afe_sel_o = AFE_INT;
        if (ph == INT_LAST) nstate = S_DEINT;
      end
      S_DEINT: begin
        afe_sel_o = AFE_DEINT;
        if (flip || sat) nstate = S_ACCUM;
      end
      S_ACCUM: begin
        afe_sel_o = AFE_AZ;
        push      = last_conv;
        nstate    = last_conv ? S_NEXT : S_SETTLE;
      end
      S_NEXT: begin
        afe_sel_o = AFE_AZ;
        if (nxt[CH_W]) begin
          nstate = S_SETTLE;
        end else begin
          irq_n  = 1'b1;
          nstate = continuous_i ? S_SETTLE : S_IDLE;
        end
      end
      default: nstate = S_IDLE;
    endcase
    if (abort_i) begin
      nstate = S_IDLE;
      push   = 1'b0;
      irq_n  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mask    <= '0;
      ch      <= '0;
      ph      <= '0;
      cnt     <= '0;
      sign    <= 1'b0;
      ovr     <= 1'b0;
      acc     <= '0;
      ovr_acc <= 1'b0;
      conv    <= '0;
      ovf     <= 1'b0;
      irq     <= 1'b0;
    end else begin
      irq <= irq_n;
      if (push && full && !res_ready_i) ovf <= 1'b1;
      if (abort_i) begin
        acc     <= '0;
        ovr_acc <= 1'b0;
        conv    <= '0;
        ph      <= '0;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (start_i && first[CH_W]) begin
              mask    <= ch_mask_i;
              ch      <= first[CH_W-1:0];
              ovf     <= 1'b0;
              acc     <= '0;
              ovr_acc <= 1'b0;
              conv    <= '0;
            end
          end
          S_SETTLE: ph <= '0;
          S_AZ: ph <= (ph == AZ_LAST) ? '0 : ph + 1'b1;
          S_INT: begin
            if (ph == INT_LAST) begin
              ph   <= '0;
              sign <= comp_i;
              cnt  <= '0;
              ovr  <= 1'b0;
            end else begin
              ph <= ph + 1'b1;
            end
          end
          // cnt holds the exit-cycle count for ACCUM.
          S_DEINT: begin
            if (!flip) begin
              if (sat) ovr <= 1'b1;
              else     cnt <= cnt + 1'b1;
            end
          end
          S_ACCUM: begin
            if (last_conv) begin
              acc     <= '0;
              ovr_acc <= 1'b0;
              conv    <= '0;
            end else begin
              acc     <= acc_sum;
              ovr_acc <= ovr_acc | ovr;
              conv    <= conv + 1'b1;
            end
          end
          S_NEXT: begin
            if (nxt[CH_W])
              ch <= nxt[CH_W-1:0];
            else if (continuous_i && restart[CH_W])
              ch <= restart[CH_W-1:0];
          end
          default: ;
        endcase
      end
    end
  end

  meas_result_fifo #(
    .WIDTH (RES_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (res_ready_i),
    .data_o  (res_data_o),
    .empty_o (empty),
    .full_o  (full)
  );

  assign ch_sel_o    = ch;
  assign ref_sign_o  = sign;
  assign busy_o      = (state != S_IDLE);
  assign res_valid_o = !empty;
  assign fifo_ovf_o  = ovf;
  assign irq_o       = irq;

endmodule

// File: doc/meas_sequencer.md
Name: meas_sequencer

Overview:
Parametrised multi-channel dual-slope conversion sequencer; successor to the single-channel state machine/counter cluster under the voltmeter digital top. Scans an enabled channel mask, runs autozero/integrate/de-integrate per conversion and detects polarity and overrange. Averages 2^AVG_LOG2 conversions per channel and buffers results in a FIFO with a valid/ready read port for the SPI layer. Inputs comp_i and analog_ready_i arrive already synchronised and filtered.

Parameters:
NUM_CH, 4, number of analog channels (1..8); CH_W = max(1, clog2(NUM_CH))
CNT_W, 12, de-integrate counter width; overrange at 2^CNT_W-1
INT_CYCLES, 1024, fixed integrate-phase length in clk_i cycles (≥2)
AZ_CYCLES, 64, autozero-phase length in clk_i cycles (≥1)
AVG_LOG2, 2, log2 of conversions averaged per result (0..4)
FIFO_DEPTH, 8, result FIFO entries (power of two, ≥2)

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous reset, active-high
start_i  in  1  one-cycle pulse: begin a scan (ignored unless IDLE)
continuous_i  in  1  1 = restart the scan automatically after the last channel
abort_i  in  1  one-cycle pulse: return to IDLE, discard the partial accumulation
ch_mask_i  in  NUM_CH  enabled channels, sampled on start
comp_i  in  1  integrator comparator (1 = integrator output positive)
analog_ready_i  in  1  AFE settled after a channel/phase change
afe_sel_o  out  2  00 idle, 01 autozero, 10 integrate, 11 de-integrate
ch_sel_o  out  CH_W  analog mux channel
ref_sign_o  out  1  de-integrate reference polarity
busy_o  out  1  high in any state except IDLE
res_data_o  out  CH_W+2+CNT_W  {ch, ovr, sign, avg_count}
res_valid_o  out  1  FIFO not empty
res_ready_i  in  1  consumer pops when valid&ready
fifo_ovf_o  out  1  sticky; set when a push is dropped because the FIFO is full; cleared by start_i
irq_o  out  1  one-cycle pulse when the last enabled channel's result is pushed

Behaviour:
- Reset: every output is 0, FIFO empty, state IDLE, all counters and the accumulator cleared.
- States: IDLE -> SETTLE -> AUTOZERO -> INTEGRATE -> DEINT -> ACCUM -> (SETTLE | NEXT_CH) ; NEXT_CH -> SETTLE | IDLE.
- IDLE: on start_i with ch_mask_i != 0, latch the mask, clear fifo_ovf_o, select the lowest set bit as ch_sel_o, and go to SETTLE. A start with mask 0 is a no-op.
- SETTLE: afe_sel_o=01. Hold until analog_ready_i=1, then go to AUTOZERO on the next cycle.
- AUTOZERO: afe_sel_o=01 for exactly AZ_CYCLES cycles.
- INTEGRATE: afe_sel_o=10 for exactly INT_CYCLES cycles. On the last cycle, register sign = comp_i and drive ref_sign_o = comp_i.
- DEINT: afe_sel_o=11. The counter starts at 0 and increments each cycle.
  - Exit when comp_i != the registered sign; the count is the value on that cycle.
  - If the count reaches 2^CNT_W-1 first, set ovr=1, saturate the count, and exit.
- ACCUM: add the count into a CNT_W+AVG_LOG2 accumulator and OR ovr into a sticky flag.
  - After 2^AVG_LOG2 conversions, push {ch, ovr_sticky, sign_of_last, acc>>AVG_LOG2} (truncating).
  - Then clear the accumulator and go to NEXT_CH. Otherwise go back to SETTLE on the same channel.
- NEXT_CH: go to the next higher set mask bit, without wrap.
  - If none remains: pulse irq_o. With continuous_i=1, restart from the lowest set bit; otherwise go to IDLE.
  - ch_sel_o changes only in NEXT_CH and IDLE.
- FIFO is synchronous and first-word-fall-through: res_data_o is valid the same cycle as res_valid_o.
  - Push and pop in the same cycle when full: both succeed, no overflow.
  - Push when full with no pop: drop the new result and set fifo_ovf_o.
  - Pop when empty is ignored.
- abort_i (any state): go to IDLE next cycle, afe_sel_o=00, accumulator cleared; FIFO contents retained. abort_i beats start_i if both are high.
- rst_i mid-conversion: same as power-on reset, FIFO flushed.
- A start_i pulse while busy is ignored.

Decomposition:
- meas_pkg holds the afe_sel encodings (AFE_IDLE/AZ/INT/DEINT), the state enum, and a result-word field-offset localparam function of CH_W/CNT_W.
- One sub-module, meas_result_fifo (parametrised WIDTH/DEPTH, FWFT, full/empty, sync reset). The sequencer FSM, counters and accumulator stay in meas_sequencer.

Test Plan:
- Case 1: NUM_CH=4, AVG_LOG2=0, mask=4'b0101, comp model flips 300 cycles into DEINT. Result: two results, ch0 then ch2, count=300, ovr=0; irq_o pulses once; busy_o falls.
- Case 2: AVG_LOG2=2, ch1 only, de-integrate counts 100, 101, 102, 104. Result: single result with count=101 (407>>2) and ch=1.
- Case 3: comp never flips in DEINT. Result: count=4095, ovr=1, ref_sign_o matches comp at the end of integrate.
- Case 4: FIFO_DEPTH=2, res_ready_i=0, continuous_i=1, mask=1. Result: after 3 results, res_valid_o=1 with the first two retained and fifo_ovf_o=1. A subsequent start clears fifo_ovf_o.
- Case 5: abort_i mid-INTEGRATE. Result: next cycle afe_sel_o=00, busy_o=0, no push. A new start yields a correct fresh result with no residual accumulation.
- Case 6: comp_i=0 at the end of integrate and flips at 50. Result: sign=0, ref_sign_o=0, count=50. Simultaneous push and pop on a full FIFO keeps the occupancy constant.
